// File: rtl/string_gen_if.sv
// Byte-stream handshake bundle between string_gen and its sink.
interface string_gen_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  // Generator side drives the byte and its qualifiers.
  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  // Sink side only drives backpressure.
  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/string_gen.sv
// string_gen: emits digit/operator ASCII streams such as "1*4+1" from an 8-bit LFSR.
// Each stream starts and ends with a digit, so every complete stream is a valid expression.
module string_gen (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [3:0]      len,
  input  logic [7:0]      seed,
  string_gen_if.master    m_out,
  output logic            busy,
  output logic            done
);

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_OP    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic [LFSR_W-1:0]   w_lfsr_adv;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                w_hs;
  logic [3:0]          w_digit;
  logic [BYTE_W-1:0]   w_digit_byte;
  logic [BYTE_W-1:0]   w_op_byte;

  // Fibonacci LFSR step, taps 8/6/5/4.
  assign w_lfsr_adv = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // Low nibble folded into 0..9 so every value maps onto a decimal digit.
  assign w_digit      = (r_lfsr[3:0] >= 4'd10) ? (r_lfsr[3:0] - 4'd10) : r_lfsr[3:0];
  assign w_digit_byte = 8'h30 + BYTE_W'(w_digit);

  // Operator choice from the two low LFSR bits.
  always_comb begin
    w_op_byte = 8'h2B;
    case (r_lfsr[1:0])
      2'd0:    w_op_byte = 8'h2B;
      2'd1:    w_op_byte = 8'h2D;
      2'd2:    w_op_byte = 8'h2A;
      default: w_op_byte = 8'h2F;
    endcase
  end

  // Stream outputs are a pure function of state and LFSR, so they hold while stalled.
  always_comb begin
    m_out.out_valid = 1'b0;
    m_out.out_data  = 8'h00;
    m_out.out_last  = 1'b0;
    case (r_state)
      S_DIGIT: begin
        m_out.out_valid = 1'b1;
        m_out.out_data  = w_digit_byte;
        m_out.out_last  = (r_cnt == 4'd1);
      end
      S_OP: begin
        m_out.out_valid = 1'b1;
        m_out.out_data  = w_op_byte;
      end
      default: begin
        m_out.out_valid = 1'b0;
      end
    endcase
  end

  assign w_hs = m_out.out_valid && m_out.out_ready;

  // Next-state logic: LFSR and digit count only move on an accepted byte.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_lfsr_nxt  = (seed == 8'h00) ? 8'h01 : seed;
          w_cnt_nxt   = (len == 4'd0) ? 4'd1 : len;
          w_state_nxt = S_DIGIT;
        end
      end
      S_DIGIT: begin
        if (w_hs) begin
          w_lfsr_nxt = w_lfsr_adv;
          if (r_cnt == 4'd1) begin
            w_cnt_nxt   = 4'd0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = r_cnt - 4'd1;
            w_state_nxt = S_OP;
          end
        end
      end
      S_OP: begin
        if (w_hs) begin
          w_lfsr_nxt  = w_lfsr_adv;
          w_state_nxt = S_DIGIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, LFSR, count and done registers; clr abandons any stream in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_lfsr  <= 8'h01;
      r_cnt   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_string_gen.sv
// Self-checking bench for string_gen: directed stream table, stall/reset/restart
// sequences, and a randomized loopback into a small expression recognizer.
module tb_string_gen;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [3:0] len;
  logic [7:0] seed;
  logic       busy;
  logic       done;

  string_gen_if u_if ();

  string_gen dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .len   (len),
    .seed  (seed),
    .m_out (u_if.master),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      seed;
    logic [3:0]      len;
    logic [3:0]      nbytes;
    logic [4:0][7:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] s, input logic [3:0] l, input logic [3:0] n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
    vec_t v;
    v.seed   = s;
    v.len    = l;
    v.nbytes = n;
    v.exp[0] = b0;
    v.exp[1] = b1;
    v.exp[2] = b2;
    v.exp[3] = b3;
    v.exp[4] = b4;
    return v;
  endfunction

  // Raise start for one edge; returns with the first byte on the bus.
  task automatic start_stream(input logic [7:0] s, input logic [3:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    seed  = s;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Check the byte currently presented, then let one edge pass.
  task automatic expect_byte(input string name, input logic [7:0] b, input logic last);
    chk({name, "_valid"}, 32'(u_if.out_valid), 32'd1);
    chk({name, "_data"},  32'(u_if.out_data),  32'(b));
    chk({name, "_last"},  32'(u_if.out_last),  32'(last));
    chk({name, "_busy"},  32'(busy),           32'd1);
    @(posedge clk); #1;
  endtask

  // Reference LFSR and byte decoding for the loopback model.
  function automatic logic [7:0] m_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] m_digit(input logic [7:0] l);
    int n;
    n = int'(l[3:0]);
    if (n >= 10) n = n - 10;
    return 8'(8'h30 + n);
  endfunction

  function automatic logic [7:0] m_op(input logic [7:0] l);
    case (l[1:0])
      2'd0:    return 8'h2B;
      2'd1:    return 8'h2D;
      2'd2:    return 8'h2A;
      default: return 8'h2F;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    vecs[0] = mk(8'h01, 4'd3, 4'd5, 8'h31, 8'h2A, 8'h34, 8'h2B, 8'h31);
    vecs[1] = mk(8'h00, 4'd0, 4'd1, 8'h31, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[2] = mk(8'h01, 4'd1, 4'd1, 8'h31, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[3] = mk(8'hFF, 4'd2, 4'd3, 8'h35, 8'h2A, 8'h32, 8'h00, 8'h00);
    vecs[4] = mk(8'h0A, 4'd2, 4'd3, 8'h30, 8'h2D, 8'h31, 8'h00, 8'h00);
    vecs[5] = mk(8'h80, 4'd2, 4'd3, 8'h30, 8'h2D, 8'h32, 8'h00, 8'h00);

    clr            = 1'b1;
    start          = 1'b0;
    len            = 4'd0;
    seed           = 8'h00;
    u_if.out_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_data",  32'(u_if.out_data),  32'd0);
    chk("rst_last",  32'(u_if.out_last),  32'd0);
    chk("rst_busy",  32'(busy),           32'd0);
    chk("rst_done",  32'(done),           32'd0);
    @(posedge clk); #1;
    clr = 1'b0;

    // Table: full-rate streams with ready held high.
    for (int v = 0; v < 6; v++) begin
      start_stream(vecs[v].seed, vecs[v].len);
      for (int i = 0; i < int'(vecs[v].nbytes); i++)
        expect_byte($sformatf("vec%0d_b%0d", v, i), vecs[v].exp[i], i == int'(vecs[v].nbytes) - 1);
      chk($sformatf("vec%0d_end_valid", v), 32'(u_if.out_valid), 32'd0);
      chk($sformatf("vec%0d_done", v),      32'(done),           32'd1);
      chk($sformatf("vec%0d_end_busy", v),  32'(busy),           32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_clr", v),  32'(done),           32'd0);
    end

    // Backpressure: stall three cycles on the operator byte.
    start_stream(8'h01, 4'd2);
    expect_byte("bp_b0", 8'h31, 1'b0);
    u_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_stall%0d_valid", i), 32'(u_if.out_valid), 32'd1);
      chk($sformatf("bp_stall%0d_data", i),  32'(u_if.out_data),  32'h2A);
      chk($sformatf("bp_stall%0d_last", i),  32'(u_if.out_last),  32'd0);
    end
    u_if.out_ready = 1'b1;
    expect_byte("bp_b1", 8'h2A, 1'b0);
    expect_byte("bp_b2", 8'h34, 1'b1);
    chk("bp_done", 32'(done), 32'd1);

    // Start ignored mid-stream, then back-to-back start in the done cycle.
    start_stream(8'h01, 4'd3);
    expect_byte("ign_b0", 8'h31, 1'b0);
    expect_byte("ign_b1", 8'h2A, 1'b0);
    start = 1'b1;
    len   = 4'd15;
    seed  = 8'hFF;
    expect_byte("ign_b2", 8'h34, 1'b0);
    start = 1'b0;
    expect_byte("ign_b3", 8'h2B, 1'b0);
    expect_byte("ign_b4", 8'h31, 1'b1);
    chk("ign_done",  32'(done),           32'd1);
    chk("ign_valid", 32'(u_if.out_valid), 32'd0);
    start = 1'b1;
    seed  = 8'h0A;
    len   = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_clr", 32'(done), 32'd0);
    expect_byte("b2b_b0", 8'h30, 1'b0);
    expect_byte("b2b_b1", 8'h2D, 1'b0);
    expect_byte("b2b_b2", 8'h31, 1'b1);
    chk("b2b_done", 32'(done), 32'd1);

    // Asynchronous clear mid-stream, then a clean restart.
    start_stream(8'h01, 4'd3);
    expect_byte("clr_b0", 8'h31, 1'b0);
    clr = 1'b1;
    #1;
    chk("clr_valid", 32'(u_if.out_valid), 32'd0);
    chk("clr_data",  32'(u_if.out_data),  32'd0);
    chk("clr_busy",  32'(busy),           32'd0);
    chk("clr_done",  32'(done),           32'd0);
    @(posedge clk); #1;
    chk("clr_hold_done", 32'(done), 32'd0);
    clr = 1'b0;
    @(posedge clk); #1;
    chk("clr_after_done", 32'(done), 32'd0);
    start_stream(8'h01, 4'd1);
    expect_byte("clr_restart", 8'h31, 1'b1);
    chk("clr_restart_done", 32'(done), 32'd1);

    // Loopback: random seeds/lengths and random ready into a digit(op digit)* recognizer.
    for (int s = 0; s < 100; s++) begin
      logic [7:0] sd;
      logic [3:0] ln;
      logic [7:0] m_lfsr;
      logic [7:0] exp_b;
      int         m_cnt;
      int         nb;
      int         rec;
      int         cyc;
      bit         finished;
      sd       = 8'($urandom_range(0, 255));
      ln       = 4'($urandom_range(0, 15));
      m_lfsr   = (sd == 8'h00) ? 8'h01 : sd;
      m_cnt    = (ln == 4'd0) ? 1 : int'(ln);
      nb       = 0;
      rec      = 0;
      cyc      = 0;
      finished = 1'b0;
      start_stream(sd, ln);
      while (!finished && cyc < 1000) begin
        u_if.out_ready = 1'($urandom_range(0, 1));
        if (u_if.out_valid && u_if.out_ready) begin
          exp_b = (nb % 2 == 0) ? m_digit(m_lfsr) : m_op(m_lfsr);
          chk($sformatf("loop%0d_b%0d", s, nb), 32'(u_if.out_data), 32'(exp_b));
          if (u_if.out_data >= 8'h30 && u_if.out_data <= 8'h39)
            rec = (rec == 0) ? 1 : 2;
          else if (u_if.out_data == 8'h2B || u_if.out_data == 8'h2D ||
                   u_if.out_data == 8'h2A || u_if.out_data == 8'h2F)
            rec = (rec == 1) ? 0 : 2;
          else
            rec = 2;
          m_lfsr = m_next(m_lfsr);
          nb++;
          if (u_if.out_last) begin
            chk($sformatf("loop%0d_accept", s), 32'(rec), 32'd1);
            chk($sformatf("loop%0d_count", s),  32'(nb),  32'(2 * m_cnt - 1));
            finished = 1'b1;
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
      if (!finished)
        chk($sformatf("loop%0d_timeout", s), 32'd0, 32'd1);
      else
        chk($sformatf("loop%0d_done", s), 32'(done), 32'd1);
      u_if.out_ready = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
